// File: rtl/sm_result_sseg_fmt.sv
// sm_result_sseg_fmt
// Converts a sign-magnitude result into four seven-segment patterns for the
// 4-digit display multiplexer. The magnitude goes through an iterative
// shift-add-3 (double-dabble) engine, one bit per clock. When it finishes,
// the three BCD digits and a sign digit are encoded and written at the same
// time, so the display never shows a partial result.
//
// Ports
//   clk      system clock, rising edge
//   reset_n  asynchronous active-low reset
//   start    conversion request, sampled only while idle
//   sign     result sign (1 = negative), latched on the accepting edge
//   mag      result magnitude, latched on the accepting edge
//   busy     high while a conversion is in flight
//   done     one-cycle pulse; dig0..dig3 were updated on the same edge
//   dig0     ones digit pattern (rightmost)
//   dig1     tens digit pattern
//   dig2     hundreds digit pattern
//   dig3     sign digit pattern (leftmost)
//
// Segment patterns are {g,f,e,d,c,b,a}, active-low.
//
// state | meaning
// IDLE  | waiting for start; outputs hold the last result
// CONV  | one double-dabble iteration per clock, MAG_W clocks in total
// OUT   | encode the BCD digits and update all four patterns at once

module sm_result_sseg_fmt #(
    parameter int MAG_W = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             sign,
    input  logic [MAG_W-1:0] mag,
    output logic             busy,
    output logic             done,
    output logic [6:0]       dig0,
    output logic [6:0]       dig1,
    output logic [6:0]       dig2,
    output logic [6:0]       dig3
);

    localparam int CNT_W = $clog2(MAG_W + 1);
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_MINUS = 7'b0111111;
    localparam logic [6:0] SEG_ZERO  = 7'b1000000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        OUT  = 2'd2
    } state_t;

    state_t             state, state_nx;
    logic               sign_q;
    logic [MAG_W-1:0]   shreg;
    logic [11:0]        bcd;
    logic [11:0]        bcd_adj;
    logic [CNT_W-1:0]   cnt;

    function automatic logic [3:0] add3(input logic [3:0] n);
        return (n >= 4'd5) ? n + 4'd3 : n;
    endfunction

    function automatic logic [6:0] seg7(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

    // Correction is applied to the current nibbles before the shift.
    assign bcd_adj = {add3(bcd[11:8]), add3(bcd[7:4]), add3(bcd[3:0])};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = CONV;
            CONV:    if (cnt == CNT_W'(1)) state_nx = OUT;
            OUT:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sign_q <= 1'b0;
            shreg  <= '0;
            bcd    <= '0;
            cnt    <= '0;
            done   <= 1'b0;
            dig0   <= SEG_ZERO;
            dig1   <= SEG_BLANK;
            dig2   <= SEG_BLANK;
            dig3   <= SEG_BLANK;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        sign_q <= sign;
                        shreg  <= mag;
                        bcd    <= '0;
                        cnt    <= CNT_W'(MAG_W);
                    end
                end
                CONV: begin
                    bcd   <= {bcd_adj[10:0], shreg[MAG_W-1]};
                    shreg <= shreg << 1;
                    cnt   <= cnt - CNT_W'(1);
                end
                OUT: begin
                    done <= 1'b1;
                    dig0 <= seg7(bcd[3:0]);
                    dig1 <= (bcd[11:4] == 8'd0) ? SEG_BLANK : seg7(bcd[7:4]);
                    dig2 <= (bcd[11:8] == 4'd0) ? SEG_BLANK : seg7(bcd[11:8]);
                    // A zero magnitude leaves all-zero BCD, so negative zero shows no minus.
                    dig3 <= (sign_q && (bcd != 12'd0)) ? SEG_MINUS : SEG_BLANK;
                end
                default: ;
            endcase
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_sm_result_sseg_fmt.sv
module tb_sm_result_sseg_fmt;

    localparam int MAG_W = 8;
    localparam logic [6:0] BLANK = 7'b1111111;
    localparam logic [6:0] MINUS = 7'b0111111;
    localparam logic [6:0] SEG [0:9] = '{7'b1000000, 7'b1111001, 7'b0100100,
                                         7'b0110000, 7'b0011001, 7'b0010010,
                                         7'b0000010, 7'b1111000, 7'b0000000,
                                         7'b0010000};

    logic             clk = 1'b0;
    logic             reset_n;
    logic             start;
    logic             sign;
    logic [MAG_W-1:0] mag;
    logic             busy, done;
    logic [6:0]       dig0, dig1, dig2, dig3;

    int n_checks = 0;
    int n_pass   = 0;
    logic chk_en = 1'b0;

    sm_result_sseg_fmt #(.MAG_W(MAG_W)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .sign(sign), .mag(mag),
        .busy(busy), .done(done),
        .dig0(dig0), .dig1(dig1), .dig2(dig2), .dig3(dig3)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Expected pattern for display position pos (0 = ones .. 3 = sign).
    function automatic logic [6:0] exp_dig(input int pos, input logic s, input int v);
        int h, t, o;
        h = v / 100;
        t = (v / 10) % 10;
        o = v % 10;
        case (pos)
            0:       return SEG[o];
            1:       return (v < 10)  ? BLANK : SEG[t];
            2:       return (v < 100) ? BLANK : SEG[h];
            default: return (s && v != 0) ? MINUS : BLANK;
        endcase
    endfunction

    // Behavioural model: a conversion is a countdown of MAG_W+1 edges from
    // acceptance, after which the decimal rendering of the latched value appears.
    int         m_rem;
    logic       m_sign;
    int         m_mag;
    logic       m_done;
    logic [6:0] m_d0, m_d1, m_d2, m_d3;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_rem  <= 0;
            m_done <= 1'b0;
            m_sign <= 1'b0;
            m_mag  <= 0;
            m_d0   <= SEG[0];
            m_d1   <= BLANK;
            m_d2   <= BLANK;
            m_d3   <= BLANK;
        end else begin
            m_done <= 1'b0;
            if (m_rem == 0) begin
                if (start) begin
                    m_rem  <= MAG_W + 1;
                    m_sign <= sign;
                    m_mag  <= int'(mag);
                end
            end else begin
                m_rem <= m_rem - 1;
                if (m_rem == 1) begin
                    m_done <= 1'b1;
                    m_d0   <= exp_dig(0, m_sign, m_mag);
                    m_d1   <= exp_dig(1, m_sign, m_mag);
                    m_d2   <= exp_dig(2, m_sign, m_mag);
                    m_d3   <= exp_dig(3, m_sign, m_mag);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en)
            chk("cycle_outputs", {2'b0, busy, done, dig3, dig2, dig1, dig0},
                {2'b0, (m_rem != 0), m_done, m_d3, m_d2, m_d1, m_d0});
    end

    task automatic chk_digs(input string name, input logic [6:0] e3, input logic [6:0] e2,
                            input logic [6:0] e1, input logic [6:0] e0);
        chk(name, {4'b0, dig3, dig2, dig1, dig0}, {4'b0, e3, e2, e1, e0});
    endtask

    // Starts a conversion from the current cycle and returns once done is seen.
    // junk_at > 0 pulses start (with a random mag) in that cycle while busy.
    task automatic do_conv(input logic s, input int v, input int junk_at,
                           output int lat, output int busy_n);
        int cyc;
        logic [31:0] vv;
        vv = v;
        sign = s;
        mag = vv[MAG_W-1:0];
        start = 1'b1;
        cyc = 0;
        lat = -1;
        busy_n = 0;
        while (cyc < 40 && lat < 0) begin
            @(negedge clk); #1;
            cyc++;
            if (cyc == 1) start = 1'b0;
            if (done === 1'b1) begin
                lat = cyc - 1;
            end else begin
                if (busy === 1'b1) busy_n++;
                if (cyc == junk_at) begin
                    start = 1'b1;
                    mag = MAG_W'($urandom);
                end else if (cyc == junk_at + 1) begin
                    start = 1'b0;
                end
            end
        end
        chk("latency", lat, MAG_W + 1);
        chk("busy_cycles", busy_n, MAG_W + 1);
    endtask

    initial begin
        int lat, bn, gap;
        logic rs;
        int rv;
        reset_n = 1'b0;
        start = 1'b0;
        sign = 1'b0;
        mag = '0;
        repeat (2) @(negedge clk);
        #1;
        chk("reset_state", {busy, done, dig3, dig2, dig1, dig0},
            {1'b0, 1'b0, BLANK, BLANK, BLANK, 7'b1000000});
        reset_n = 1'b1;
        chk_en = 1'b1;
        @(negedge clk); #1;

        do_conv(1'b0, 0, 0, lat, bn);
        chk_digs("pos_zero", BLANK, BLANK, BLANK, 7'b1000000);
        do_conv(1'b1, 255, 0, lat, bn);
        chk_digs("neg_255", 7'b0111111, 7'b0100100, 7'b0010010, 7'b0010010);
        do_conv(1'b1, 7, 0, lat, bn);
        chk_digs("neg_7", 7'b0111111, BLANK, BLANK, 7'b1111000);
        do_conv(1'b1, 0, 0, lat, bn);
        chk_digs("neg_zero", BLANK, BLANK, BLANK, 7'b1000000);
        do_conv(1'b0, 105, 0, lat, bn);
        chk_digs("pos_105", BLANK, 7'b1111001, 7'b1000000, 7'b0010010);

        // Start during CONV is ignored; start in the done cycle is accepted.
        do_conv(1'b0, 200, 4, lat, bn);
        chk_digs("ignore_busy_start", BLANK, 7'b0100100, 7'b1000000, 7'b1000000);
        do_conv(1'b0, 9, 0, lat, bn);
        chk_digs("back_to_back_9", BLANK, BLANK, BLANK, 7'b0010000);

        // Abort mid-conversion.
        sign = 1'b0;
        mag = MAG_W'(123);
        start = 1'b1;
        @(negedge clk); #1;
        start = 1'b0;
        repeat (3) begin @(negedge clk); #1; end
        reset_n = 1'b0;
        #1;
        chk("abort_reset", {busy, done, dig3, dig2, dig1, dig0},
            {1'b0, 1'b0, BLANK, BLANK, BLANK, 7'b1000000});
        @(negedge clk); #1;
        reset_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk); #1;
            chk("abort_no_done", {busy, done}, 2'b00);
        end
        do_conv(1'b0, 123, 0, lat, bn);
        chk_digs("after_abort_123", BLANK, 7'b1111001, 7'b0100100, 7'b0110000);

        // Randomized conversions with gaps and ignored mid-conversion starts.
        for (int i = 0; i < 40; i++) begin
            rs = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 4))
                0:       rv = $urandom_range(0, 9);
                1:       rv = $urandom_range(10, 99);
                default: rv = $urandom_range(0, (1 << MAG_W) - 1);
            endcase
            do_conv(rs, rv, ($urandom_range(0, 1) == 1) ? $urandom_range(2, MAG_W) : 0, lat, bn);
            gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) begin
                @(negedge clk); #1;
            end
        end

        repeat (3) @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
